// File: rtl/seq_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in on valid/ready, bits out MSB-first one per clock.
// Define SER_PARITY_EN to append an even-parity bit after each word's LSB.
module seq_serializer #(
  parameter int   WIDTH    = 8,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             arstn,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             ser_out,
  output logic             ser_active,
  output logic             word_done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef SER_PARITY_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_PARITY = 2'd2} state_e;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1} state_e;
`endif

  state_e           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ser_out_q;
  logic             ser_active_q;
  logic             word_done_q;
`ifdef SER_PARITY_EN
  logic             parity_q;
`endif
  logic             transfer;

  // cnt_q counts the bits still to come after the one currently on ser_out.
  always_comb begin
    // NOTE: default assignment first so every path drives din_ready and no latch is inferred.
    din_ready = 1'b0;
    case (state_q)
      ST_IDLE:   din_ready = 1'b1;
`ifdef SER_PARITY_EN
      ST_SHIFT:  din_ready = 1'b0;
      ST_PARITY: din_ready = 1'b1;
`else
      ST_SHIFT:  din_ready = (cnt_q == '0);
`endif
      default:   din_ready = 1'b0;
    endcase
  end

  assign transfer = din_valid && din_ready;

  // The MSB is registered straight onto ser_out at the accepting edge, so a
  // reload during the final bit cycle streams the next word without a gap.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      // NOTE: every register, including the shift register, gets an async reset so a
      // mid-word reset discards the word completely.
      state_q      <= ST_IDLE;
      shreg_q      <= '0;
      cnt_q        <= '0;
      ser_out_q    <= IDLE_BIT;
      ser_active_q <= 1'b0;
      word_done_q  <= 1'b0;
`ifdef SER_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else if (transfer) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q      <= ST_SHIFT;
      ser_out_q    <= din[WIDTH-1];
      shreg_q      <= din << 1;
      cnt_q        <= CNT_W'(WIDTH - 1);
      ser_active_q <= 1'b1;
`ifdef SER_PARITY_EN
      word_done_q  <= 1'b0;
      parity_q     <= ^din;
`else
      word_done_q  <= (WIDTH == 1);
`endif
    end else if (state_q == ST_SHIFT && cnt_q != '0) begin
      ser_out_q    <= shreg_q[WIDTH-1];
      shreg_q      <= shreg_q << 1;
      cnt_q        <= cnt_q - CNT_W'(1);
      ser_active_q <= 1'b1;
`ifdef SER_PARITY_EN
      word_done_q  <= 1'b0;
`else
      word_done_q  <= (cnt_q == CNT_W'(1));
`endif
    end
`ifdef SER_PARITY_EN
    else if (state_q == ST_SHIFT) begin
      state_q      <= ST_PARITY;
      ser_out_q    <= parity_q;
      ser_active_q <= 1'b1;
      word_done_q  <= 1'b1;
    end
`endif
    else begin
      state_q      <= ST_IDLE;
      ser_out_q    <= IDLE_BIT;
      ser_active_q <= 1'b0;
      word_done_q  <= 1'b0;
    end
  end

  assign ser_out    = ser_out_q;
  assign ser_active = ser_active_q;
  assign word_done  = word_done_q;

endmodule

// File: tb/tb_seq_serializer.sv
// Directed bench for seq_serializer (WIDTH=8, IDLE_BIT=0); parity steps run when SER_PARITY_EN is defined.
module tb_seq_serializer;

  logic       clk;
  logic       arstn;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       ser_out;
  logic       ser_active;
  logic       word_done;

  int checks = 0;
  int errors = 0;

  seq_serializer #(.WIDTH(8), .IDLE_BIT(1'b0)) dut (
    .clk        (clk),
    .arstn      (arstn),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .ser_out    (ser_out),
    .ser_active (ser_active),
    .word_done  (word_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are driven and outputs sampled here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".ser_out"},    {31'd0, ser_out},    32'd0);
    check({tag, ".ser_active"}, {31'd0, ser_active}, 32'd0);
    check({tag, ".word_done"},  {31'd0, word_done},  32'd0);
    check({tag, ".din_ready"},  {31'd0, din_ready},  32'd1);
  endtask

  logic [7:0]  word;
  logic [15:0] stream;

  initial begin
    arstn     = 1'b0;
    din       = 8'h00;
    din_valid = 1'b0;

    // Reset held for three cycles, then released.
    repeat (3) step();
    check("rst_hold.ser_out",    {31'd0, ser_out},    32'd0);
    check("rst_hold.ser_active", {31'd0, ser_active}, 32'd0);
    arstn = 1'b1;
    step();
    check_idle("reset");

`ifndef SER_PARITY_EN
    // Single word 8'hA0; din changes right after acceptance and must not matter.
    word = 8'hA0;
    din = word; din_valid = 1'b1;
    step();
    din = 8'h3C; din_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("single.bit%0d", i),    {31'd0, ser_out},    {31'd0, word[7-i]});
      check($sformatf("single.active%0d", i), {31'd0, ser_active}, 32'd1);
      check($sformatf("single.done%0d", i),   {31'd0, word_done},  {31'd0, (i == 7)});
      check($sformatf("single.ready%0d", i),  {31'd0, din_ready},  {31'd0, (i == 7)});
      step();
    end
    check_idle("single_end");

    // Back-to-back A5 then 5A with valid held high: 16 gapless data cycles.
    stream = 16'hA55A;
    din = 8'hA5; din_valid = 1'b1;
    step();
    din = 8'h5A;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("b2b.bit%0d", i),    {31'd0, ser_out},    {31'd0, stream[15-i]});
      check($sformatf("b2b.active%0d", i), {31'd0, ser_active}, 32'd1);
      check($sformatf("b2b.done%0d", i),   {31'd0, word_done},  {31'd0, (i == 7 || i == 15)});
      check($sformatf("b2b.ready%0d", i),  {31'd0, din_ready},  {31'd0, (i == 7 || i == 15)});
      if (i == 8) din_valid = 1'b0;
      step();
    end
    check_idle("b2b_end");

    // Word 8'h00 with a stray valid of 8'hFF while din_ready is low.
    din = 8'h00; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("ignore.bit%0d", i),    {31'd0, ser_out},    32'd0);
      check($sformatf("ignore.active%0d", i), {31'd0, ser_active}, 32'd1);
      if (i == 2) begin
        check("ignore.ready_low", {31'd0, din_ready}, 32'd0);
        din = 8'hFF; din_valid = 1'b1;
      end
      if (i == 3) din_valid = 1'b0;
      step();
    end
    check_idle("ignore_end");
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("ignore.no_extra%0d", i), {31'd0, ser_active}, 32'd0);
    end

    // Reset asserted in the middle of word 8'hFF.
    din = 8'hFF; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    repeat (3) step();
    check("midrst.before", {31'd0, ser_out}, 32'd1);
    #2 arstn = 1'b0;
    #1;
    check("midrst.ser_out_async",    {31'd0, ser_out},    32'd0);
    check("midrst.ser_active_async", {31'd0, ser_active}, 32'd0);
    check("midrst.word_done_async",  {31'd0, word_done},  32'd0);
    repeat (2) step();
    arstn = 1'b1;
    step();
    check_idle("midrst_release");
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("midrst.quiet_out%0d", i),    {31'd0, ser_out},    32'd0);
      check($sformatf("midrst.quiet_active%0d", i), {31'd0, ser_active}, 32'd0);
    end
`else
    // Word 8'h07 followed by its even-parity bit (three ones -> 1).
    word = 8'h07;
    din = word; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("par.bit%0d", i),    {31'd0, ser_out},    {31'd0, word[7-i]});
      check($sformatf("par.active%0d", i), {31'd0, ser_active}, 32'd1);
      check($sformatf("par.done%0d", i),   {31'd0, word_done},  32'd0);
      check($sformatf("par.ready%0d", i),  {31'd0, din_ready},  32'd0);
      step();
    end
    check("par.parity_bit", {31'd0, ser_out},    32'd1);
    check("par.active",     {31'd0, ser_active}, 32'd1);
    check("par.done",       {31'd0, word_done},  32'd1);
    check("par.ready",      {31'd0, din_ready},  32'd1);
    step();
    check_idle("par_end");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
